// File: rtl/audio_pkg.sv
// Shared audio constants and the PCM width-conversion rule used by every capture-path stage.
package audio_pkg;

    localparam int DEFAULT_DATA_SIZE = 24;
    localparam int DEFAULT_OUT_SIZE  = 16;

    // Sample arrives sign-extended to 64 bits; narrowing keeps the MSBs (arithmetic
    // shift drops LSBs, no rounding), widening is already done by the sign extension.
    function automatic logic signed [63:0] pcm_resize(input logic signed [63:0] sample,
                                                      input int data_size,
                                                      input int out_size);
        if (out_size < data_size) begin
            return sample >>> (data_size - out_size);
        end
        return sample;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Sample buffer between I2S capture and its consumer: converts width at write,
// stores in a circular buffer, and counts samples dropped on overflow.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int OUT_SIZE  = DEFAULT_OUT_SIZE,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_SIZE-1:0]     sample_in,
    input  logic                     sample_valid,
    input  logic                     flush,
    output logic [OUT_SIZE-1:0]      m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int EXT = 64 - DATA_SIZE;
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         level_q;
    logic                overflow_q;
    logic [15:0]         drop_q;
    logic [OUT_SIZE-1:0] wr_data;
    logic                full;
    logic                push;
    logic                pop;
    logic                wr_en;
    logic                drop;

    assign wr_data = OUT_SIZE'(pcm_resize({{EXT{sample_in[DATA_SIZE-1]}}, sample_in},
                                          DATA_SIZE, OUT_SIZE));

    // Stream: a beat transfers on any cycle with m_valid & m_ready; m_data and
    // m_valid hold steady until that cycle, and m_ready is ignored while m_valid is low.
    assign full  = (level_q == FULL_LEVEL);
    assign push  = sample_valid;
    assign pop   = m_valid & m_ready;
    assign wr_en = push & (~full | pop) & ~flush;
    assign drop  = push & full & ~pop & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !pop) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (pop && !wr_en) begin
                level_q <= level_q - (AW+1)'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_SIZE),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (m_data)
    );

    assign m_valid    = (level_q != '0);
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
